fadd_arbiter: RTL and testbench
===============================

// Module: fadd_arbiter
// PURPOSE
//   Shares one combinational single-precision adder (fadd: s,t -> d,overflow) among
//   NREQ requesters. Round-robin arbitration accepts up to one op per cycle.
//   Each op is an add or a subtract. Results go through a LAT-stage register
//   pipeline tagged with the requester index, and return on per-requester
//   valid/ready handshakes. Sits between the FPU-issuing units and the fadd
//   instance; fadd is instantiated outside this block and wired to the fadd_* ports.
// PARAMETERS
//   NREQ  4  number of requesters (2..8)
//   LAT   2  result pipeline depth in cycles (1..4), accept-to-response latency
// PORTS
//   clk            in   1          clock, all state on rising edge
//   rstn           in   1          synchronous reset, active low
//   req_valid      in   NREQ       requester i has an op pending
//   req_ready      out  NREQ       op of requester i accepted this cycle (one-hot or 0)
//   req_s          in   32*NREQ    operand s of requester i at [32*i+:32]
//   req_t          in   32*NREQ    operand t of requester i at [32*i+:32]
//   req_sub        in   NREQ       1: compute s - t, 0: compute s + t
//   fadd_s         out  32         operand s to shared fadd
//   fadd_t         out  32         operand t to shared fadd (sign-adjusted)
//   fadd_d         in   32         fadd result, same cycle
//   fadd_overflow  in   1          fadd overflow flag, same cycle
//   resp_valid     out  NREQ       result for requester i is on resp_d (one-hot or 0)
//   resp_ready     in   NREQ       requester i takes the result
//   resp_d         out  32         result word
//   resp_overflow  out  1          overflow flag of that result
//   inflight       out  3          ops accepted but not yet consumed (0..LAT)
//   ovf_sticky     out  1          set by any consumed result with overflow=1
//   ovf_clr        in   1          clears ovf_sticky
// BEHAVIOUR
//   Reset (rstn=0 at edge): all stage valids 0, rr pointer = NREQ-1, inflight=0,
//   ovf_sticky=0. Outputs then: req_ready=0, resp_valid=0, resp_d=0,
//   resp_overflow=0. Ops in flight are discarded without response.
//   Pipeline: stages 1..LAT, each holding {valid, tag, d, ovf}. Stage LAT drives resp_*.
//   advance = !vLAT | resp_ready[tagLAT]. If advance=0, all stages hold and
//   nothing is accepted (global stall). Bubbles are not squeezed out.
//   Arbitration: grant = first i with req_valid[i], searching ptr+1, ptr+2, ...
//   modulo NREQ. req_ready[grant] = advance & |req_valid. req_ready is
//   combinational from req_valid; requesters must not make valid depend on ready.
//   Accept (advance & grant exists): ptr <= grant.
//   Stage 1 <= {1, grant, fadd_d, fadd_overflow}. If no grant, stage 1 valid <= 0.
//   fadd_s = req_s[grant]. fadd_t = {req_t[grant][31]^req_sub[grant], req_t[grant][30:0]}.
//   With no grant, fadd_s/t = requester 0's operands (don't care).
//   Sign flip applies to NaN/inf/zero as-is; the result is what fadd returns.
//   Latency: op accepted at edge N -> resp_valid[i] high from edge N+LAT-1
//   (visible in cycle N+LAT). Held until resp_ready[i]. Throughput 1 op/cycle.
//   Stages only move when advance=1. resp_d/resp_overflow stay stable while resp_valid is high.
//   inflight: +1 on accept, -1 on consume (resp_valid & resp_ready). Both in the
//   same cycle: unchanged. Saturates naturally at LAT.
//   ovf_sticky: ovf_clr has priority over a same-cycle set, so the flag reads 0.
//   resp_ready[j] for j != tagLAT is ignored. resp_ready with resp_valid=0 has no effect.
// TESTING
//   T1 add: rq0 s=3F800000 t=40000000 sub=0 -> LAT cycles later resp_valid=0001,
//      resp_d=40400000, resp_overflow=0, inflight 1->0 on consume.
//   T2 sub/sign: rq2 s=40400000 t=3F800000 sub=1 -> resp_d=40000000 on resp_valid[2].
//      Check fadd_t=BF800000 at accept.
//   T3 round-robin: all 4 valid for 8 cycles, resp_ready=1111 -> grant order
//      0,1,2,3,0,1,2,3. Responses in the same order, 1 per cycle.
//   T4 stall: rq1 result at output with resp_ready[1]=0 for 5 cycles, others
//      valid -> req_ready=0, resp_d stable, no loss. Resume -> order kept.
//   T5 overflow: s=t=7F7FFFFF add -> resp_d=7F800000, resp_overflow=1, ovf_sticky=1.
//      Assert ovf_clr together with a second overflow result -> ovf_sticky=0 that cycle.
//   T6 reset mid-op: 2 ops in flight, rstn=0 for 1 cycle -> no resp_valid afterwards,
//      inflight=0, next grant goes to requester 0.

Source files
------------

// File: rtl/fadd_arbiter.sv
// fadd_arbiter: round-robin front end that shares one combinational fadd
// among NREQ requesters. One op (add or subtract) is accepted per cycle. The
// fadd result is tagged with the requester index and carried through a
// LAT-stage pipeline, then returned on a per-requester valid/ready handshake.
//
// Ports
//   clk, rstn                  clock, synchronous active-low reset
//   req_valid/req_ready        per-requester op handshake (ready is one-hot or 0)
//   req_s/req_t/req_sub        packed operands ([32*i+:32]) and subtract select
//   fadd_s/fadd_t              operands to the shared fadd (t sign-adjusted)
//   fadd_d/fadd_overflow       same-cycle fadd result
//   resp_valid/resp_ready      per-requester result handshake (valid one-hot or 0)
//   resp_d/resp_overflow       result word and its overflow flag
//   inflight                   ops accepted but not yet consumed
//   ovf_sticky/ovf_clr         sticky overflow of consumed results, and its clear
module fadd_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned LAT  = 2
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [32*NREQ-1:0]     req_s,
  input  logic [32*NREQ-1:0]     req_t,
  input  logic [NREQ-1:0]        req_sub,
  output logic [31:0]            fadd_s,
  output logic [31:0]            fadd_t,
  input  logic [31:0]            fadd_d,
  input  logic                   fadd_overflow,
  output logic [NREQ-1:0]        resp_valid,
  input  logic [NREQ-1:0]        resp_ready,
  output logic [31:0]            resp_d,
  output logic                   resp_overflow,
  output logic [2:0]             inflight,
  output logic                   ovf_sticky,
  input  logic                   ovf_clr
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned TAG_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CNT_W  = TAG_W + 1;

  // One pipeline stage: valid, requester tag, fadd result and overflow flag
  typedef struct packed {
    logic              vld;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] d;
    logic              ovf;
  } stage_t;

  stage_t [LAT-1:0]  stg_q;
  stage_t [LAT-1:0]  stg_nxt;
  stage_t            stg_in;
  stage_t            out_stg;

  logic [TAG_W-1:0]  ptr_q;
  logic [TAG_W-1:0]  gnt_idx;
  logic [CNT_W-1:0]  cand_sum;
  logic              gnt_found;
  logic              advance;
  logic              accept;
  logic              consume;

  logic [DATA_W-1:0] s_arr [NREQ];
  logic [DATA_W-1:0] t_arr [NREQ];

  // Unpacked views of the packed operand buses
  for (genvar i = 0; i < NREQ; i++) begin : g_split
    assign s_arr[i] = req_s[DATA_W*i +: DATA_W];
    assign t_arr[i] = req_t[DATA_W*i +: DATA_W];
  end

  assign out_stg = stg_q[LAT-1];

  // The whole pipeline moves only when the output slot is empty or being taken
  assign advance = !out_stg.vld || resp_ready[out_stg.tag];
  assign accept  = advance && gnt_found;
  assign consume = out_stg.vld && resp_ready[out_stg.tag];

  // Round-robin search starting just after the last granted requester
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand_sum  = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand_sum = {1'b0, ptr_q} + CNT_W'(k);
      if (cand_sum >= CNT_W'(NREQ)) begin
        cand_sum = cand_sum - CNT_W'(NREQ);
      end
      if (!gnt_found && req_valid[cand_sum[TAG_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand_sum[TAG_W-1:0];
      end
    end
  end

  // Ready goes only to the granted requester, and only if the pipe can move
  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  // Operand steering; with no grant gnt_idx is 0 so requester 0 is presented.
  // Subtraction is an add with t's sign bit flipped, whatever t encodes.
  assign fadd_s = s_arr[gnt_idx];
  assign fadd_t = {t_arr[gnt_idx][DATA_W-1] ^ req_sub[gnt_idx], t_arr[gnt_idx][DATA_W-2:0]};

  assign stg_in = '{vld: gnt_found, tag: gnt_idx, d: fadd_d, ovf: fadd_overflow};

  // Next pipeline contents when advancing: new entry in stage 1, rest shift up
  if (LAT == 1) begin : g_one_stage
    assign stg_nxt = stg_in;
  end else begin : g_multi_stage
    assign stg_nxt = {stg_q[LAT-2:0], stg_in};
  end

  // Pipeline, pointer, occupancy and sticky overflow state
  always_ff @(posedge clk) begin
    if (!rstn) begin
      stg_q      <= '0;
      ptr_q      <= TAG_W'(NREQ - 1);
      inflight   <= 3'd0;
      ovf_sticky <= 1'b0;
    end else begin
      if (advance) begin
        stg_q <= stg_nxt;
      end
      if (accept) begin
        ptr_q <= gnt_idx;
      end
      if (accept && !consume) begin
        inflight <= inflight + 3'd1;
      end else if (!accept && consume) begin
        inflight <= inflight - 3'd1;
      end
      // Clear wins over a same-cycle overflow
      if (ovf_clr) begin
        ovf_sticky <= 1'b0;
      end else if (consume && out_stg.ovf) begin
        ovf_sticky <= 1'b1;
      end
    end
  end

  // Response side is driven straight from the last stage
  always_comb begin
    resp_valid = '0;
    if (out_stg.vld) begin
      resp_valid[out_stg.tag] = 1'b1;
    end
  end

  assign resp_d        = out_stg.vld ? out_stg.d : '0;
  assign resp_overflow = out_stg.vld && out_stg.ovf;

endmodule

// File: tb/tb_fadd_arbiter.sv
// Testbench for fadd_arbiter: a reference fadd drives the shared-adder ports,
// a behavioural model of the arbiter is compared every cycle, and directed
// scenarios pin the model with hand-computed values.
module tb_fadd_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned LAT  = 2;

  logic              clk = 1'b0;
  logic              rstn;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [32*NREQ-1:0] req_s;
  logic [32*NREQ-1:0] req_t;
  logic [NREQ-1:0]   req_sub;
  logic [31:0]       fadd_s;
  logic [31:0]       fadd_t;
  logic [31:0]       fadd_d;
  logic              fadd_overflow;
  logic [NREQ-1:0]   resp_valid;
  logic [NREQ-1:0]   resp_ready;
  logic [31:0]       resp_d;
  logic              resp_overflow;
  logic [2:0]        inflight;
  logic              ovf_sticky;
  logic              ovf_clr;

  int n_cmp = 0;
  int n_err = 0;

  fadd_arbiter #(.NREQ(NREQ), .LAT(LAT)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_s(req_s), .req_t(req_t), .req_sub(req_sub),
    .fadd_s(fadd_s), .fadd_t(fadd_t), .fadd_d(fadd_d), .fadd_overflow(fadd_overflow),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_d(resp_d), .resp_overflow(resp_overflow),
    .inflight(inflight), .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [NREQ-1:0] onehot(input int i);
    logic [NREQ-1:0] r;
    r = {{(NREQ-1){1'b0}}, 1'b1} << i;
    return r;
  endfunction

  function automatic logic bit_at(input logic [NREQ-1:0] v, input int i);
    logic [NREQ-1:0] s;
    s = v >> i;
    return s[0];
  endfunction

  function automatic logic [31:0] word_at(input logic [32*NREQ-1:0] v, input int i);
    logic [32*NREQ-1:0] s;
    s = v >> (32 * i);
    return s[31:0];
  endfunction

  // Single precision to real (subnormals flushed to zero)
  function automatic real sp2real(input logic [31:0] a);
    logic [63:0] b;
    if (a[30:23] == 8'd0)       b = {a[31], 63'd0};
    else if (a[30:23] == 8'hFF) b = {a[31], 11'h7FF, a[22:0], 29'd0};
    else                        b = {a[31], 11'(int'(a[30:23]) - 127 + 1023), a[22:0], 29'd0};
    return $bitstoreal(b);
  endfunction

  // Reference fadd: {overflow, d}; finite operands exceeding range give inf + overflow
  function automatic logic [32:0] fadd_ref(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    logic [22:0] m;
    int e;
    r = $realtobits(sp2real(a) + sp2real(b));
    m = r[51:29];
    if (r[62:52] == 11'h7FF) begin
      if (r[51:0] != 52'd0) m[22] = 1'b1;
      return {1'b0, r[63], 8'hFF, m};
    end
    if (r[62:52] == 11'd0) return {1'b0, r[63], 31'd0};
    e = int'(r[62:52]) - 1023 + 127;
    if (e >= 255) return {1'b1, r[63], 8'hFF, 23'd0};
    if (e <= 0)   return {1'b0, r[63], 31'd0};
    return {1'b0, r[63], 8'(e), m};
  endfunction

  always_comb {fadd_overflow, fadd_d} = fadd_ref(fadd_s, fadd_t);

  // ---------------- behavioural model + per-cycle compare ----------------
  logic        mknown = 1'b0;
  logic        mv   [1:LAT];
  int          mtag [1:LAT];
  logic [31:0] md   [1:LAT];
  logic        mo   [1:LAT];
  int          mlast;
  logic        msticky;

  always @(negedge clk) begin : mon
    logic        adv;
    logic        fnd;
    logic        cons;
    int          g;
    int          cnt;
    logic [31:0] et;
    logic [32:0] res;
    adv = 1'b0; fnd = 1'b0; cons = 1'b0; g = 0; et = '0;
    if (mknown) begin
      adv = !mv[LAT] || bit_at(resp_ready, mtag[LAT]);
      for (int k = 1; k <= int'(NREQ); k++) begin
        if (!fnd && bit_at(req_valid, (mlast + k) % NREQ)) begin
          fnd = 1'b1;
          g   = (mlast + k) % NREQ;
        end
      end
      chk("req_ready", 32'(req_ready), 32'((adv && fnd) ? onehot(g) : {NREQ{1'b0}}));
      if (fnd) begin
        et = word_at(req_t, g);
        et[31] = et[31] ^ bit_at(req_sub, g);
        chk("fadd_s", fadd_s, word_at(req_s, g));
        chk("fadd_t", fadd_t, et);
      end
      chk("resp_valid", 32'(resp_valid), 32'(mv[LAT] ? onehot(mtag[LAT]) : {NREQ{1'b0}}));
      if (mv[LAT]) begin
        chk("resp_d", resp_d, md[LAT]);
        chk("resp_overflow", 32'(resp_overflow), 32'(mo[LAT]));
      end
      cnt = 0;
      for (int k = 1; k <= int'(LAT); k++) if (mv[k]) cnt++;
      chk("inflight", 32'(inflight), 32'(cnt));
      chk("ovf_sticky", 32'(ovf_sticky), 32'(msticky));
    end
    if (!rstn) begin
      mknown  = 1'b1;
      mlast   = NREQ - 1;
      msticky = 1'b0;
      for (int k = 1; k <= int'(LAT); k++) mv[k] = 1'b0;
    end else if (mknown) begin
      cons = mv[LAT] && bit_at(resp_ready, mtag[LAT]);
      if (ovf_clr) msticky = 1'b0;
      else if (cons && mo[LAT]) msticky = 1'b1;
      if (adv) begin
        for (int k = int'(LAT); k >= 2; k--) begin
          mv[k] = mv[k-1]; mtag[k] = mtag[k-1]; md[k] = md[k-1]; mo[k] = mo[k-1];
        end
        mv[1] = fnd;
        if (fnd) begin
          res     = fadd_ref(word_at(req_s, g), et);
          mtag[1] = g;
          md[1]   = res[31:0];
          mo[1]   = res[32];
          mlast   = g;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] s, input logic [31:0] t, input logic sub);
    logic [32*NREQ-1:0] mask;
    mask  = {{(32*NREQ-32){1'b0}}, 32'hFFFF_FFFF} << (32 * i);
    req_s = (req_s & ~mask) | ({{(32*NREQ-32){1'b0}}, s} << (32 * i));
    req_t = (req_t & ~mask) | ({{(32*NREQ-32){1'b0}}, t} << (32 * i));
    req_sub = sub ? (req_sub | onehot(i)) : (req_sub & ~onehot(i));
  endtask

  // Issue one op, wait for its result, then consume it (optionally with ovf_clr)
  task automatic single_op(input string nm, input int i, input logic [31:0] s, input logic [31:0] t,
                           input logic sub, input logic [31:0] exp_t, input logic [31:0] exp_d,
                           input logic exp_ovf, input logic clr, input logic exp_sticky);
    int got;
    int lat_seen;
    set_req(i, s, t, sub);
    req_valid = onehot(i);
    @(negedge clk);
    chk({nm, "_req_ready"}, 32'(req_ready), 32'(onehot(i)));
    chk({nm, "_fadd_t"}, fadd_t, exp_t);
    tick();
    req_valid = '0;
    got = 0;
    lat_seen = -1;
    for (int c = 0; c < 8 && got == 0; c++) begin
      @(negedge clk);
      if (resp_valid != '0) begin
        got = 1;
        lat_seen = c;
      end else begin
        tick();
      end
    end
    chk({nm, "_resp_seen"}, 32'(got), 32'd1);
    if (got != 0) begin
      chk({nm, "_latency"}, 32'(lat_seen), 32'(LAT - 1));
      chk({nm, "_resp_valid"}, 32'(resp_valid), 32'(onehot(i)));
      chk({nm, "_resp_d"}, resp_d, exp_d);
      chk({nm, "_resp_ovf"}, 32'(resp_overflow), 32'(exp_ovf));
      chk({nm, "_inflight_busy"}, 32'(inflight), 32'd1);
    end
    tick();
    resp_ready = onehot(i);
    ovf_clr    = clr;
    @(negedge clk);
    tick();
    resp_ready = '0;
    ovf_clr    = 1'b0;
    @(negedge clk);
    chk({nm, "_inflight_done"}, 32'(inflight), 32'd0);
    chk({nm, "_sticky"}, 32'(ovf_sticky), 32'(exp_sticky));
    chk({nm, "_resp_gone"}, 32'(resp_valid), 32'd0);
    tick();
  endtask

  logic [NREQ-1:0] gq[$];
  logic [NREQ-1:0] rq[$];

  initial begin
    rstn = 1'b0; req_valid = '0; resp_ready = '0; req_s = '0; req_t = '0;
    req_sub = '0; ovf_clr = 1'b0;
    tick(); tick();
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_d", resp_d, 32'd0);
    chk("rst_resp_ovf", 32'(resp_overflow), 32'd0);
    chk("rst_inflight", 32'(inflight), 32'd0);
    chk("rst_sticky", 32'(ovf_sticky), 32'd0);
    tick();

    // T1 add, T2 subtract with sign flip on t
    single_op("t1", 0, 32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4000_0000, 32'h4040_0000, 1'b0, 1'b0, 1'b0);
    single_op("t2", 2, 32'h4040_0000, 32'h3F80_0000, 1'b1, 32'hBF80_0000, 32'h4000_0000, 1'b0, 1'b0, 1'b0);

    // T3 round-robin from reset: all requesters valid for 8 cycles
    rstn = 1'b0; tick(); tick(); rstn = 1'b1;
    set_req(0, 32'h3F80_0000, 32'h0000_0000, 1'b0);
    set_req(1, 32'h3F80_0000, 32'h3F80_0000, 1'b0);
    set_req(2, 32'h3F80_0000, 32'h4000_0000, 1'b0);
    set_req(3, 32'h3F80_0000, 32'h4040_0000, 1'b0);
    resp_ready = '1;
    for (int c = 0; c < 8 + int'(LAT) + 3; c++) begin
      req_valid = (c < 8) ? '1 : '0;
      @(negedge clk);
      if (req_ready != '0) gq.push_back(req_ready);
      if (resp_valid != '0) rq.push_back(resp_valid);
      tick();
    end
    chk("rr_grant_count", 32'(gq.size()), 32'd8);
    chk("rr_resp_count", 32'(rq.size()), 32'd8);
    for (int k = 0; k < 8; k++) begin
      if (k < gq.size()) chk($sformatf("rr_grant_%0d", k), 32'(gq[k]), 32'(onehot(k % 4)));
      if (k < rq.size()) chk($sformatf("rr_resp_%0d", k), 32'(rq[k]), 32'(onehot(k % 4)));
    end
    resp_ready = '0;

    // T4 stall: requester 1's result blocked for 5 cycles while others wait
    set_req(0, 32'h3F80_0000, 32'h3F80_0000, 1'b0);
    set_req(1, 32'h40A0_0000, 32'h3F80_0000, 1'b0);
    set_req(2, 32'h4120_0000, 32'h4000_0000, 1'b1);
    set_req(3, 32'h4000_0000, 32'h4000_0000, 1'b0);
    resp_ready = 4'b1101;
    req_valid  = 4'b0010;
    @(negedge clk);
    chk("stall_grant_a", 32'(req_ready), 32'h2);
    tick();
    req_valid = 4'b1101;
    @(negedge clk);
    chk("stall_grant_b", 32'(req_ready), 32'h4);
    tick();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_req_ready", 32'(req_ready), 32'd0);
      chk("stall_resp_valid", 32'(resp_valid), 32'h2);
      chk("stall_resp_d", resp_d, 32'h40C0_0000);
      tick();
    end
    resp_ready = '1;
    req_valid  = '0;
    @(negedge clk);
    chk("resume_first_valid", 32'(resp_valid), 32'h2);
    chk("resume_first_d", resp_d, 32'h40C0_0000);
    tick();
    @(negedge clk);
    chk("resume_second_valid", 32'(resp_valid), 32'h4);
    chk("resume_second_d", resp_d, 32'h4100_0000);
    tick();
    @(negedge clk);
    chk("resume_drained", 32'(inflight), 32'd0);
    tick();
    resp_ready = '0;

    // T5 overflow sets the sticky flag; clear wins over a second overflow
    single_op("t5a", 0, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F7F_FFFF, 32'h7F80_0000, 1'b1, 1'b0, 1'b1);
    single_op("t5b", 0, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F7F_FFFF, 32'h7F80_0000, 1'b1, 1'b1, 1'b0);

    // T6 reset with two ops in flight
    set_req(1, 32'h3F80_0000, 32'h3F80_0000, 1'b0);
    set_req(3, 32'h4000_0000, 32'h3F80_0000, 1'b1);
    req_valid = 4'b1010;
    @(negedge clk);
    chk("t6_grant_a", 32'(req_ready), 32'h2);
    tick();
    @(negedge clk);
    chk("t6_grant_b", 32'(req_ready), 32'h8);
    tick();
    req_valid = '0;
    rstn = 1'b0;
    @(negedge clk);
    chk("t6_inflight_pre", 32'(inflight), 32'd2);
    tick();
    rstn = 1'b1;
    resp_ready = '1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t6_no_resp", 32'(resp_valid), 32'd0);
      chk("t6_inflight", 32'(inflight), 32'd0);
      tick();
    end
    req_valid = '1;
    @(negedge clk);
    chk("t6_first_grant", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    for (int c = 0; c < int'(LAT) + 2; c++) tick();
    resp_ready = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
